// File: rtl/dff_rsp_checker.sv
// dff_rsp_checker: checks that q equals d from one clock earlier, counts
// mismatches, runs a cycle watchdog and holds a sticky pass/fail verdict.
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   chk_en      arm / keep checking (low aborts to IDLE)
//   end_req     end-of-test request, only honoured in CHECK
//   d, q        value driven into the dff and the dff output
//   err         one-cycle pulse per mismatching compare
//   err_cnt     mismatch count, saturates at MAX_ERRS
//   chk_cnt     compares performed, saturates at 65535
//   state       IDLE=0 ARM=1 CHECK=2 PASS=3 FAIL=4
//   done, pass, fail, timeout  verdict flags
module dff_rsp_checker #(
  parameter int WIDTH          = 1,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int MAX_ERRS       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             end_req,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [15:0]      chk_cnt,
  output logic [2:0]       state,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] PASS  = 3'd3;
  localparam logic [2:0] FAIL  = 3'd4;

  localparam logic [7:0]  ERR_MAX = 8'(MAX_ERRS);
  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYCLES);

  logic [WIDTH-1:0] exp_q;
  logic [15:0]      cyc_cnt;

  logic        mismatch;
  logic [7:0]  err_cnt_nxt;
  logic [15:0] chk_cnt_nxt;
  logic [15:0] cyc_cnt_nxt;

  // Post-update values: the exit decisions look at the count
  // including the compare made on this same edge.
  always_comb begin
    mismatch    = (q != exp_q);
    err_cnt_nxt = err_cnt;
    if (mismatch && (err_cnt < ERR_MAX))
      err_cnt_nxt = err_cnt + 8'd1;
    chk_cnt_nxt = chk_cnt;
    if (chk_cnt != 16'hffff)
      chk_cnt_nxt = chk_cnt + 16'd1;
    cyc_cnt_nxt = cyc_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      exp_q   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
      chk_cnt <= '0;
      cyc_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (chk_en)
            state <= ARM;
        end
        ARM: begin
          exp_q   <= d;
          err_cnt <= '0;
          chk_cnt <= '0;
          cyc_cnt <= '0;
          state   <= chk_en ? CHECK : IDLE;
        end
        CHECK: begin
          // err reports this edge's compare even when the
          // same edge moves the FSM into a verdict state.
          exp_q   <= d;
          err     <= mismatch;
          err_cnt <= err_cnt_nxt;
          chk_cnt <= chk_cnt_nxt;
          cyc_cnt <= cyc_cnt_nxt;
          if (!chk_en)
            state <= IDLE;
          else if (err_cnt_nxt == ERR_MAX)
            state <= FAIL;
          else if (end_req)
            state <= (err_cnt_nxt == 8'd0) ? PASS : FAIL;
          else if (cyc_cnt_nxt == TO_MAX) begin
            state   <= FAIL;
            timeout <= 1'b1;
          end
        end
        PASS, FAIL: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pass = (state == PASS);
  assign fail = (state == FAIL);
  assign done = pass | fail;

endmodule

// File: tb/tb_dff_rsp_checker.sv
// tb_dff_rsp_checker: scenario table plus hand sequences for
// dff_rsp_checker, with a per-cycle scoreboard of expected outputs.
module tb_dff_rsp_checker;

  localparam int W    = 4;
  localparam int TO   = 50;
  localparam int MAXE = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         chk_en = 1'b0;
  logic         end_req = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q = '0;
  logic         err;
  logic [7:0]   err_cnt;
  logic [15:0]  chk_cnt;
  logic [2:0]   state;
  logic         done, pass, fail, timeout;

  dff_rsp_checker #(
    .WIDTH(W), .TIMEOUT_CYCLES(TO), .MAX_ERRS(MAXE)
  ) dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .end_req(end_req),
    .d(d), .q(q), .err(err), .err_cnt(err_cnt), .chk_cnt(chk_cnt),
    .state(state), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; logic er; int ec; int cc; logic to;
  } exp_t;

  typedef struct {
    string        name;
    bit           stuck;
    int           fault_k;
    logic [W-1:0] mask;
    int           end_k;
    int           x_state;
    int           x_ec;
    int           x_cc;
    logic         x_to;
    int           x_pulses;
  } scn_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   pulses;

  int           m_st, m_ec, m_cc, m_cyc;
  logic         m_err, m_to;
  logic [W-1:0] m_exp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ec = 0; m_cc = 0; m_cyc = 0;
    m_err = 0; m_to = 0; m_exp = '0;
    sb.delete();
  endtask

  task automatic model_step(input logic ce, input logic er,
                            input logic [W-1:0] dd,
                            input logic [W-1:0] qq);
    exp_t e;
    bit mis;
    case (m_st)
      0: begin m_err = 0; if (ce) m_st = 1; end
      1: begin
        m_err = 0; m_exp = dd; m_ec = 0; m_cc = 0; m_cyc = 0;
        m_st = ce ? 2 : 0;
      end
      2: begin
        mis = (qq != m_exp);
        m_err = mis;
        m_exp = dd;
        if (m_cc < 65535) m_cc++;
        if (mis && m_ec < MAXE) m_ec++;
        m_cyc++;
        if (!ce) m_st = 0;
        else if (m_ec == MAXE) m_st = 4;
        else if (er) m_st = (m_ec == 0) ? 3 : 4;
        else if (m_cyc == TO) begin m_st = 4; m_to = 1; end
      end
      default: m_err = 0;
    endcase
    e.st = m_st; e.er = m_err; e.ec = m_ec; e.cc = m_cc; e.to = m_to;
    sb.push_back(e);
  endtask

  // Called at a negedge: drive, predict, clock, then check.
  task automatic tick(input logic ce, input logic er,
                      input logic [W-1:0] dd, input logic [W-1:0] qq);
    exp_t e;
    chk_en = ce; end_req = er; d = dd; q = qq;
    model_step(ce, er, dd, qq);
    @(posedge clk);
    @(negedge clk);
    if (err === 1'b1) pulses++;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("state", state, e.st);
      chk("err", err, e.er);
      chk("err_cnt", err_cnt, e.ec);
      chk("chk_cnt", chk_cnt, e.cc);
      chk("timeout", timeout, e.to);
      chk("pass", pass, e.st == 3);
      chk("fail", fail, e.st == 4);
      chk("done", done, e.st >= 3);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; chk_en = 0; end_req = 0; d = '0; q = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_chk_cnt", chk_cnt, 0);
    chk("rst_flags", {err, done, pass, fail, timeout}, 0);
    pulses = 0;
  endtask

  task automatic run_scn(input scn_t s);
    logic [W-1:0] prev, dd, qq;
    int k;
    do_reset();
    prev = s.stuck ? '1 : 4'h5;
    tick(1, 0, '0, '0);
    tick(1, 0, prev, '0);
    k = 1;
    while (done !== 1'b1 && k <= 80) begin
      dd = s.stuck ? '1 : ((k % 2) ? 4'hF : 4'h0);
      qq = s.stuck ? '0 : (prev ^ ((k == s.fault_k) ? s.mask : '0));
      tick(1, k == s.end_k, dd, qq);
      prev = dd;
      k++;
    end
    if (done !== 1'b1) chk({s.name, "_cycle_budget"}, 0, 1);
    repeat (3) tick(logic'($urandom_range(0, 1)), 1'b1,
                    W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    chk({s.name, "_state"}, state, s.x_state);
    chk({s.name, "_err_cnt"}, err_cnt, s.x_ec);
    chk({s.name, "_chk_cnt"}, chk_cnt, s.x_cc);
    chk({s.name, "_timeout"}, timeout, s.x_to);
    chk({s.name, "_pulses"}, pulses, s.x_pulses);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no end want $finish");
    $fatal(1);
  end

  initial begin
    scn_t tbl[6];
    tbl[0] = '{"clean", 0, 0, 4'h0, 21, 3, 0, 21, 0, 0};
    tbl[1] = '{"single", 0, 5, 4'h4, 10, 4, 1, 10, 0, 1};
    tbl[2] = '{"errsat", 1, 0, 4'h0, 0, 4, 4, 4, 0, 4};
    tbl[3] = '{"watchdog", 0, 0, 4'h0, 0, 4, 0, 50, 1, 0};
    tbl[4] = '{"end_at_to", 0, 0, 4'h0, 50, 3, 0, 50, 0, 0};
    tbl[5] = '{"end_at_err", 0, 7, 4'hF, 7, 4, 1, 7, 0, 1};

    model_reset();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) run_scn(tbl[i]);

    // async reset mid-CHECK with two errors logged
    do_reset();
    tick(1, 0, '0, '0);
    tick(1, 0, 4'h3, '0);
    tick(1, 0, 4'h6, 4'h3);
    tick(1, 0, 4'h9, 4'h0);
    tick(1, 0, 4'hC, 4'h0);
    tick(1, 0, 4'h1, 4'hC);
    chk("mid_err_cnt_pre", err_cnt, 2);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_state", state, 0);
    chk("mid_err_cnt", err_cnt, 0);
    chk("mid_chk_cnt", chk_cnt, 0);
    chk("mid_flags", {err, done, pass, fail, timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1, 0, '0, '0);
    tick(1, 0, 4'h7, '0);
    tick(1, 0, 4'h2, 4'h7);
    chk("rearm_chk_cnt", chk_cnt, 1);
    chk("rearm_err_cnt", err_cnt, 0);

    // chk_en drop in CHECK, then end_req in IDLE is ignored
    do_reset();
    tick(1, 0, '0, '0);
    tick(1, 0, 4'hA, '0);
    tick(1, 0, 4'h5, 4'hA);
    tick(1, 0, 4'h3, 4'h4);
    tick(0, 0, 4'h8, 4'h3);
    tick(0, 1, 4'h0, 4'hF);
    chk("drop_state", state, 0);
    chk("drop_chk_cnt", chk_cnt, 3);
    chk("drop_err_cnt", err_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
